// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: pops words from an async FIFO read port and launches them to a byte-serial TX.
// Ports: clk_i/rst_ni (sync, active-low), enable_i, fifo_empty_i, fifo_rd_data_i, fifo_r_inc_o,
//   tx_busy_i, tx_data_o, tx_data_valid_o, timeout_err_o (sticky), err_clr_i,
//   sent_cnt_o/abort_cnt_o (live only with FIFO_DRAIN_STATS_EN defined, otherwise tied to 0).
module fifo_rd_drain #(
   parameter int DATA_WIDTH     = 8,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   output logic                  fifo_r_inc_o,
   input  logic                  tx_busy_i,
   output logic [DATA_WIDTH-1:0] tx_data_o,
   output logic                  tx_data_valid_o,
   output logic                  timeout_err_o,
   input  logic                  err_clr_i,
   output logic [CNT_WIDTH-1:0]  sent_cnt_o,
   output logic [CNT_WIDTH-1:0]  abort_cnt_o
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_HI = 2'd1;
   localparam logic [1:0] WAIT_LO = 2'd2;
   localparam logic [1:0] GAP     = 2'd3;
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [1:0] AFTER_TX = (GAP_CYCLES > 0) ? GAP : IDLE;
   logic [1:0]            state_q, state_d;
   logic [7:0]            to_q, to_d, gap_q, gap_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, err_q, err_d;
   logic                  launch, timeout, done;
   assign launch  = state_q == IDLE && enable_i && !fifo_empty_i && !tx_busy_i;
   assign timeout = state_q == WAIT_HI && !tx_busy_i && to_q == TO_LAST;
   assign done    = state_q == WAIT_LO && !tx_busy_i;
   assign data_d  = launch ? fifo_rd_data_i : data_q;
   // a new timeout beats a simultaneous clear
   assign err_d   = timeout | (err_q & ~err_clr_i);
   always_comb begin
      state_d = state_q;
      to_d    = to_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: if (launch) begin
            state_d = WAIT_HI;
            to_d    = '0;
         end
         WAIT_HI: if (tx_busy_i) state_d = WAIT_LO;
         else if (timeout) begin
            state_d = AFTER_TX;
            gap_d   = '0;
         end else to_d = to_q + 8'd1;
         WAIT_LO: if (done) begin
            state_d = AFTER_TX;
            gap_d   = '0;
         end
         default: if (gap_q == GAP_LAST) state_d = IDLE;
         else gap_d = gap_q + 8'd1;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         to_q    <= '0;
         gap_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         valid_q <= launch;
         err_q   <= err_d;
      end
   end
   // the pop and the launch share one flop so they can never separate
   assign fifo_r_inc_o    = valid_q;
   assign tx_data_valid_o = valid_q;
   assign tx_data_o       = data_q;
   assign timeout_err_o   = err_q;
`ifdef FIFO_DRAIN_STATS_EN
   logic [CNT_WIDTH-1:0] sent_q, abort_q;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sent_q  <= '0;
         abort_q <= '0;
      end else begin
         sent_q  <= sent_q + CNT_WIDTH'(done && !(&sent_q));
         abort_q <= abort_q + CNT_WIDTH'(timeout && !(&abort_q));
      end
   end
   assign sent_cnt_o  = sent_q;
   assign abort_cnt_o = abort_q;
`else
   assign sent_cnt_o  = '0;
   assign abort_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed bench for fifo_rd_drain with a FIFO model and a UART-like TX model.
module tb_fifo_rd_drain;
   logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, err_clr = 1'b0;
   logic       fifo_empty, r_inc, tx_busy, valid, terr;
   logic [7:0] rd_data, tx_data, sent, abort;
   logic [7:0] fmem [0:15];
   int         rp = 0, wp = 0, pops = 0, bad_pair = 0, empty_pop = 0;
   int         launches = 0, cyc = 0, busy_cnt = 0;
   bit         tx_en = 1'b0;
   logic [7:0] ldat [0:15];
   int         lcyc [0:15];
   int         n_cmp = 0, n_err = 0;
   int         base_l, base_p, base_s;
`ifdef FIFO_DRAIN_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   always #5 clk = ~clk;

   fifo_rd_drain dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .fifo_empty_i(fifo_empty),
      .fifo_rd_data_i(rd_data), .fifo_r_inc_o(r_inc), .tx_busy_i(tx_busy),
      .tx_data_o(tx_data), .tx_data_valid_o(valid), .timeout_err_o(terr),
      .err_clr_i(err_clr), .sent_cnt_o(sent), .abort_cnt_o(abort)
   );

   assign fifo_empty = (rp == wp);
   assign rd_data    = fmem[rp[3:0]];
   assign tx_busy    = busy_cnt != 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (r_inc) begin
         rp   <= rp + 1;
         pops <= pops + 1;
         if (rp == wp) empty_pop <= empty_pop + 1;
      end
      if (r_inc !== valid) bad_pair <= bad_pair + 1;
      if (valid) begin
         ldat[launches[3:0]] <= tx_data;
         lcyc[launches[3:0]] <= cyc;
         launches <= launches + 1;
      end
      if (tx_en && valid) busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      fmem[wp[3:0]] = d;
      wp = wp + 1;
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("rst_rinc", int'(r_inc), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_txdata", int'(tx_data), 0);
      check("rst_err", int'(terr), 0);
      check("rst_sent", int'(sent), 0);
      check("rst_abort", int'(abort), 0);
      // two words, TX busy 10 cycles each
      rst_n = 1'b1;
      @(negedge clk);
      tx_en  = 1'b1;
      enable = 1'b1;
      push(8'hA5);
      push(8'h3C);
      @(negedge clk);
      check("lat_valid", int'(valid), 1);
      check("lat_rinc", int'(r_inc), 1);
      check("lat_data", int'(tx_data), 8'hA5);
      @(negedge clk);
      check("one_cycle_valid", int'(valid), 0);
      for (int i = 0; i < 60 && launches < 2; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      check("t1_launches", launches, 2);
      check("t1_data0", int'(ldat[0]), 8'hA5);
      check("t1_data1", int'(ldat[1]), 8'h3C);
      // 1 cycle busy response + 10 busy + 1 detect + 2 gap + 1 idle sample
      check("t1_spacing", lcyc[1] - lcyc[0], 15);
      check("t1_pops", pops, 2);
      check("t1_sent", int'(sent), STATS ? 2 : 0);
      // empty FIFO for 100 cycles
      base_l = launches;
      repeat (100) @(negedge clk);
      check("empty_launches", launches - base_l, 0);
      check("empty_pops", pops, 2);
      // TX never busy: timeout, and set beats a concurrent clear
      tx_en = 1'b0;
      push(8'h55);
      @(negedge clk);
      check("to_launch_data", int'(tx_data), 8'h55);
      repeat (15) @(negedge clk);
      check("to_err_early", int'(terr), 0);
      err_clr = 1'b1;
      @(negedge clk);
      check("to_err_set_wins", int'(terr), 1);
      check("to_abort", int'(abort), STATS ? 1 : 0);
      check("to_pops", pops, 3);
      @(negedge clk);
      check("to_err_cleared", int'(terr), 0);
      err_clr = 1'b0;
      repeat (5) @(negedge clk);
      check("to_no_replay", launches, 3);
      // drop ENABLE while in WAIT_LO with three words queued
      tx_en = 1'b1;
      base_s = int'(sent);
      push(8'h11);
      push(8'h22);
      push(8'h33);
      @(negedge clk);
      check("en_launch_data", int'(tx_data), 8'h11);
      repeat (3) @(negedge clk);
      enable = 1'b0;
      repeat (30) @(negedge clk);
      check("en_sent_inc", int'(sent) - base_s, STATS ? 1 : 0);
      check("en_launches", launches, 4);
      check("en_pops", pops, 4);
      // re-enable with TX silent, then reset during WAIT_HI
      tx_en  = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 5 && !valid; i++) @(negedge clk);
      check("re_valid", int'(valid), 1);
      check("re_data", int'(tx_data), 8'h22);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_valid", int'(valid), 0);
      check("mrst_rinc", int'(r_inc), 0);
      check("mrst_txdata", int'(tx_data), 0);
      check("mrst_sent", int'(sent), 0);
      check("mrst_abort", int'(abort), 0);
      check("mrst_err", int'(terr), 0);
      rst_n = 1'b1;
      tx_en = 1'b1;
      base_p = pops;
      @(negedge clk);
      check("post_rst_valid", int'(valid), 1);
      check("post_rst_data", int'(tx_data), 8'h33);
      repeat (30) @(negedge clk);
      check("post_rst_pops", pops - base_p, 1);
      check("post_rst_sent", int'(sent), STATS ? 1 : 0);
      check("total_pops", pops, 6);
      check("pair_errors", bad_pair, 0);
      check("empty_pop_errors", empty_pop, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
